// File: rtl/spif_arbiter.sv
// spif_arbiter -- three-way arbiter in front of a single SPI byte engine.
//
// Requesters: [0] boot loader, [1] CPU, [2] ISP. Fixed priority ISP > CPU > boot.
// The granted requester ("owner") is connected straight through to the engine.
// Its byte stream goes out; engine read bytes come back to it. When the owner
// drops req, the arbiter waits for the engine to go idle (CS_N high) before
// freeing the bus. Then there is at least one idle cycle before the next grant.
//
// Handshake (valid/ready): a byte moves from the owner to the engine on a
// rising edge where e_valid (= valid[o] & req[o]) and e_ready are both high.
// The requester holds its byte and last stable while valid is high and ready
// is low. ready[o] mirrors e_ready in OWN and is 0 in every other case.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   req[2:0]          bus request per requester
//   gnt[2:0]          registered one-hot grant
//   valid/data/last   per-requester byte stream (data[8n+7:8n] for requester n)
//   ready[2:0]        byte accepted, owner only
//   rvalid[2:0]       read byte valid, owner only
//   rdata[7:0]        read byte, broadcast to all requesters
//   tout[2:0]         one-cycle pulse marking a forcibly released owner
//   e_valid/e_data/e_last          byte request to the SPI engine
//   e_ready/e_busy/e_rvalid/e_rdata  engine accept, CS_N low, read strobe, read byte
//   dbg_state[1:0]    current FSM state (IDLE=0, OWN=1, DRAIN=2)
//
// Optional feature: define SPIF_ARB_TIMEOUT_EN to enable the owner-idle
// timeout (parameter TIMEOUT) with its per-requester re-grant mask.
module spif_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  output logic [2:0]  gnt,
  input  logic [2:0]  valid,
  input  logic [23:0] data,
  input  logic [2:0]  last,
  output logic [2:0]  ready,
  output logic [2:0]  rvalid,
  output logic [7:0]  rdata,
  output logic [2:0]  tout,
  output logic        e_valid,
  output logic [7:0]  e_data,
  output logic        e_last,
  input  logic        e_ready,
  input  logic        e_busy,
  input  logic        e_rvalid,
  input  logic [7:0]  e_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [2:0]  gnt_n;
  logic [1:0]  own;
  logic [2:0]  avail;
  logic [2:0]  mask;
  logic        force_last;
  logic        to_hit;

  assign dbg_state = state;
  assign rdata     = e_rdata;

  // Owner index comes from the registered grant, so ownership only changes
  // through the state register.
  always_comb begin
    own = 2'd0;
    if (gnt[2])      own = 2'd2;
    else if (gnt[1]) own = 2'd1;
  end

  assign avail = req & ~mask;

  // Owner pass-through to the engine.
  always_comb begin
    e_valid = 1'b0;
    e_data  = 8'h00;
    e_last  = 1'b0;
    ready   = 3'b000;
    rvalid  = 3'b000;
    if (state == S_OWN) begin
      e_valid    = valid[own] & req[own];
      e_data     = data[{own, 3'b000} +: 8];
      e_last     = last[own] | force_last;
      ready[own] = e_ready;
    end
    if (state != S_IDLE) begin
      rvalid[own] = e_rvalid;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    case (state)
      S_IDLE: begin
        // No grant while the engine still holds CS_N low.
        if ((|avail) && !e_busy) begin
          state_n = S_OWN;
          if (avail[2])      gnt_n = 3'b100;
          else if (avail[1]) gnt_n = 3'b010;
          else               gnt_n = 3'b001;
        end
      end
      S_OWN: begin
        if (!req[own]) begin
          state_n = S_DRAIN;
        end else if (to_hit && !e_busy) begin
          state_n = S_DRAIN;
        end else if (force_last && e_valid && e_ready) begin
          // The forced-last byte was accepted; the transfer closes on its own.
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!e_busy) begin
          state_n = S_IDLE;
          gnt_n   = 3'b000;
        end
      end
      default: begin
        state_n = S_IDLE;
        gnt_n   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      gnt   <= 3'b000;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
    end
  end

`ifdef SPIF_ARB_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        hs;

  assign hs = e_valid & e_ready;

  // idle_cnt is the number of consecutive handshake-free OWN cycles already
  // seen. The timeout fires on the cycle that brings that count to TIMEOUT.
  // It fires only while the owner still requests; a voluntary release wins.
  assign to_hit = (state == S_OWN) && req[own] && !hs && !force_last &&
                  (idle_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt   <= 16'd0;
      mask       <= 3'b000;
      force_last <= 1'b0;
      tout       <= 3'b000;
    end else begin
      tout <= to_hit ? gnt : 3'b000;
      // A masked requester becomes eligible again once it lets go of req.
      mask <= (mask | (to_hit ? gnt : 3'b000)) & req;
      if (state != S_OWN) begin
        // Holding the counter at zero outside OWN gives a clean start on entry.
        idle_cnt   <= 16'd0;
        force_last <= 1'b0;
      end else begin
        if (hs) begin
          idle_cnt <= 16'd0;
        end else if (idle_cnt != 16'(TIMEOUT - 1)) begin
          idle_cnt <= idle_cnt + 16'd1;
        end
        // Engine mid-transfer: close it with the next accepted byte instead.
        if (to_hit && e_busy) begin
          force_last <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_timeout;

  assign mask           = 3'b000;
  assign force_last     = 1'b0;
  assign to_hit         = 1'b0;
  assign tout           = 3'b000;
  assign unused_timeout = ^TIMEOUT;
`endif

endmodule
